// File: rtl/rr_decode_arbiter8_if.sv
// Request/grant bundle between the requesters and the round-robin decode arbiter.
interface rr_decode_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic       grant_vld;
  logic [2:0] grant_idx;
  logic [7:0] grant_oh;
  logic       timeout;

  modport master (
    output req, done,
    input  grant_vld, grant_idx, grant_oh, timeout
  );

  modport slave (
    input  req, done,
    output grant_vld, grant_idx, grant_oh, timeout
  );
endinterface

// File: rtl/rr_decode_arbiter8.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 decoded resource,
// with a bounded hold time and a one-cycle gap between grants.
module rr_decode_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_decode_arbiter8_if.slave  bus
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 32'd0) ? (MAX_HOLD - 32'd1) : 32'd0);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               grant_vld_q, grant_vld_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic [N_REQ-1:0]   grant_oh_q, grant_oh_d;
  logic               timeout_q, timeout_d;

  logic [IDX_W-1:0]   cand_c;
  logic [IDX_W-1:0]   pick_c;
  logic               pick_vld_c;
  logic               rel_done_c, rel_req_c, rel_hold_c, release_c;

  // First requester at or after ptr, wrapping modulo 8
  always_comb begin
    cand_c     = ptr_q;
    pick_c     = ptr_q;
    pick_vld_c = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_c = ptr_q + IDX_W'(k);
      if (!pick_vld_c && bus.req[cand_c]) begin
        pick_c     = cand_c;
        pick_vld_c = 1'b1;
      end
    end
  end

  always_comb begin
    rel_done_c = bus.done;
    rel_req_c  = ~bus.req[grant_idx_q];
    rel_hold_c = (MAX_HOLD != 32'd0) && (hold_cnt_q == HOLD_LAST);
    release_c  = rel_done_c | rel_req_c | rel_hold_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      grant_vld_q <= 1'b0;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_vld_q <= grant_vld_d;
      grant_idx_q <= grant_idx_d;
      grant_oh_q  <= grant_oh_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_vld_c) state_d = GRANT;
      GRANT:   if (release_c)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // grant_idx is left untouched in IDLE so the last grantee stays visible
  always_comb begin
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_vld_d = grant_vld_q;
    grant_idx_d = grant_idx_q;
    grant_oh_d  = grant_oh_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld_c) begin
          grant_vld_d = 1'b1;
          grant_idx_d = pick_c;
          grant_oh_d  = N_REQ'(1) << pick_c;
          hold_cnt_d  = '0;
        end else begin
          grant_vld_d = 1'b0;
          grant_oh_d  = '0;
        end
      end
      GRANT: begin
        if (release_c) begin
          grant_vld_d = 1'b0;
          grant_oh_d  = '0;
          ptr_d       = grant_idx_q + IDX_W'(1);
          timeout_d   = rel_hold_c & ~rel_done_c & ~rel_req_c;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        grant_vld_d = 1'b0;
        grant_oh_d  = '0;
      end
    endcase
  end

  assign bus.grant_vld = grant_vld_q;
  assign bus.grant_idx = grant_idx_q;
  assign bus.grant_oh  = grant_oh_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter8.sv
// Directed bench for rr_decode_arbiter8: a MAX_HOLD=4 instance for the main
// sequences and a default-parameter instance for the 16-cycle hold limit.
module tb_rr_decode_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  bit         mon_en = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  rr_decode_arbiter8_if bus4 ();
  rr_decode_arbiter8_if bus16 ();

  assign bus4.req   = req;
  assign bus4.done  = done;
  assign bus16.req  = req;
  assign bus16.done = done;

  rr_decode_arbiter8 #(.MAX_HOLD(4), .HOLD_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  rr_decode_arbiter8 dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    check({tag, "_vld"}, bus4.grant_vld, 1'b1);
    check({tag, "_idx"}, bus4.grant_idx, idx);
    check({tag, "_oh"},  bus4.grant_oh,  8'h01 << idx);
    check({tag, "_to"},  bus4.timeout,   1'b0);
  endtask

  task automatic check_gap(input string tag, input logic to);
    check({tag, "_vld"}, bus4.grant_vld, 1'b0);
    check({tag, "_oh"},  bus4.grant_oh,  8'h00);
    check({tag, "_to"},  bus4.timeout,   to);
  endtask

  // Two grant cycles, done on the second, check the gap, step into the next grant
  task automatic do_grant(input string tag, input logic [2:0] idx);
    check_grant({tag, "_c1"}, idx);
    step();
    check_grant({tag, "_c2"}, idx);
    done = 1'b1;
    step();
    done = 1'b0;
    check_gap({tag, "_gap"}, 1'b0);
    step();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_oh4",  bus4.grant_oh,  bus4.grant_vld  ? (8'h01 << bus4.grant_idx)  : 8'h00);
      check("inv_oh16", bus16.grant_oh, bus16.grant_vld ? (8'h01 << bus16.grant_idx) : 8'h00);
    end
  end

  initial begin
    rst  = 1'b1;
    req  = 8'hFF;
    done = 1'b0;

    // T1: reset dominates pending requests
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_vld", bus4.grant_vld, 1'b0);
      check("t1_oh",  bus4.grant_oh,  8'h00);
      check("t1_to",  bus4.timeout,   1'b0);
      check("t1_idx", bus4.grant_idx, 3'd0);
    end
    req = 8'h00;
    rst = 1'b0;
    step();
    mon_en = 1'b1;
    check_gap("t1_idle", 1'b0);

    // T2: requesters 0 and 7 alternate
    req = 8'h81;
    step();
    do_grant("t2_a", 3'd0);
    do_grant("t2_b", 3'd7);
    do_grant("t2_c", 3'd0);
    check_grant("t2_d", 3'd7);
    req = 8'h00;
    step();
    check_gap("t2_drop", 1'b0);
    step();

    // T3: full rotation with all requesting
    req = 8'hFF;
    step();
    for (int k = 0; k < 9; k++) do_grant("t3", 3'(k % 8));
    check_grant("t3_next", 3'd1);
    req = 8'h00;
    step();
    step();

    // T4: hold limit revokes after 4 cycles, then re-grant
    req = 8'h04;
    step();
    for (int c = 0; c < 4; c++) begin
      check_grant("t4_hold", 3'd2);
      if (c < 3) step();
    end
    step();
    check_gap("t4_timeout", 1'b1);
    step();
    check_grant("t4_regrant", 3'd2);

    // T5: done coinciding with the last hold cycle is a normal release
    step();
    step();
    step();
    check_grant("t5_last", 3'd2);
    done = 1'b1;
    step();
    done = 1'b0;
    check_gap("t5_release", 1'b0);
    req = 8'h00;
    step();
    check_gap("t5_idle", 1'b0);

    // T6: reset in the middle of a grant
    req = 8'h30;
    step();
    check_grant("t6_g1", 3'd4);
    step();
    check_grant("t6_g2", 3'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_vld", bus4.grant_vld, 1'b0);
    check("t6_rst_idx", bus4.grant_idx, 3'd0);
    check("t6_rst_oh",  bus4.grant_oh,  8'h00);
    check("t6_rst_to",  bus4.timeout,   1'b0);
    step();
    check_grant("t6_after", 3'd4);

    // T7: default instance holds for 16 cycles before revoking
    req = 8'h00;
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 8'h40;
    step();
    for (int c = 0; c < 16; c++) begin
      check("t7_vld", bus16.grant_vld, 1'b1);
      check("t7_idx", bus16.grant_idx, 3'd6);
      step();
    end
    check("t7_to_vld", bus16.grant_vld, 1'b0);
    check("t7_to",     bus16.timeout,   1'b1);
    step();
    check("t7_regrant", bus16.grant_vld, 1'b1);
    check("t7_to_clr",  bus16.timeout,   1'b0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
